// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch front end.
package fetch_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    PEND = 1'b1
  } state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_STEP_DEFAULT  = 32'd4;

  // One buffered entry is {pc, instr}.
  localparam int ENTRY_W = 64;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding {pc, instr} entries toward decode.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = ENTRY_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [W-1:0]           wdata,
  output logic [W-1:0]           rdata,
  output logic                   valid,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          pop_i;

  assign valid = (count != '0);
  assign pop_i = pop & valid;
  assign rdata = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      // Flush wins over any same-cycle push or pop.
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop_i) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop_i})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch sequencer: drives pc to the I-cache, honours stall and
// redirects, and buffers fetched instructions toward decode.
//
//  state | meaning
//  RUN   | issuing sequential fetches, pushing hits into the FIFO
//  PEND  | redirect arrived mid-refill; waiting for stall to drop
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter logic [31:0] PC_STEP    = PC_STEP_DEFAULT,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  output logic [31:0]                 pc,
  input  logic [31:0]                 instr,
  input  logic                        stall,
  input  logic                        redirect_valid,
  input  logic [31:0]                 redirect_pc,
  output logic                        out_valid,
  output logic [31:0]                 out_instr,
  output logic [31:0]                 out_pc,
  input  logic                        out_ready,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  state_t              state;
  logic [31:0]         pend_pc;
  logic [31:0]         target;
  logic                pop;
  logic                can_push;
  logic                accept;
  logic [ENTRY_W-1:0]  head;

  assign target   = redirect_pc & 32'hFFFF_FFFC;
  assign pop      = out_valid & out_ready;
  assign can_push = (fifo_count < DEPTH_C) | pop;
  assign accept   = (state == RUN) & ~stall & can_push & ~redirect_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RUN;
      pc      <= RESET_PC;
      pend_pc <= '0;
    end else begin
      case (state)
        RUN: begin
          if (redirect_valid) begin
            // Mid-refill the cache still owns the old pc, so park the target.
            if (stall) begin
              pend_pc <= target;
              state   <= PEND;
            end else begin
              pc <= target;
            end
          end else if (accept) begin
            pc <= pc + PC_STEP;
          end
        end
        PEND: begin
          if (stall) begin
            if (redirect_valid) pend_pc <= target;
          end else begin
            pc    <= redirect_valid ? target : pend_pc;
            state <= RUN;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (accept),
    .pop   (pop),
    .flush (redirect_valid),
    .wdata ({pc, instr}),
    .rdata (head),
    .valid (out_valid),
    .count (fifo_count)
  );

  assign out_pc    = head[63:32];
  assign out_instr = head[31:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized scoreboard bench for fetch_unit against a queue-based fetch model.
module tb_fetch_unit;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_ready;
  logic [2:0]  fifo_count;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pc             (pc),
    .instr          (instr),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_ready      (out_ready),
    .fifo_count     (fifo_count)
  );

  function automatic logic [31:0] word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // Cache model: correct data on a hit, garbage while refilling.
  assign instr = stall ? ~word(pc) : word(pc);

  int total = 0;
  int bad   = 0;

  logic [63:0] q[$];
  logic [31:0] pc_m;
  logic [31:0] pend_pc_m;
  bit          pend_m;
  int          cnt_m;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Monitor: compares whatever head the DUT presents against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (redirect_valid) begin
          q.delete();
        end else if (out_valid) begin
          if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL head_unexpected: got pc %h want none", out_pc);
          end else begin
            chk("head_pc", out_pc, q[0][63:32]);
            chk("head_instr", out_instr, q[0][31:0]);
            if (out_ready) void'(q.pop_front());
          end
        end
      end
    end
  end

  task automatic check_state();
    chk("pc", pc, pc_m);
    chk("fifo_count", {29'd0, fifo_count}, cnt_m);
    chk("out_valid", {31'd0, out_valid}, {31'd0, (cnt_m != 0)});
  endtask

  // Called just after a rising edge: drive inputs, advance the model, wait one edge.
  task automatic step(input logic st, input logic rv, input logic [31:0] rpc, input logic rdy);
    logic [31:0] tgt;
    bit          pop_m;
    stall          = st;
    redirect_valid = rv;
    redirect_pc    = rpc;
    out_ready      = rdy;
    tgt   = {rpc[31:2], 2'b00};
    pop_m = (cnt_m > 0) && rdy;
    if (!pend_m) begin
      if (rv) begin
        cnt_m = 0;
        if (st) begin
          pend_m    = 1'b1;
          pend_pc_m = tgt;
        end else begin
          pc_m = tgt;
        end
      end else if (!st && (cnt_m < DEPTH || pop_m)) begin
        q.push_back({pc_m, word(pc_m)});
        cnt_m = cnt_m + 1 - int'(pop_m);
        pc_m  = pc_m + 32'd4;
      end else begin
        cnt_m = cnt_m - int'(pop_m);
      end
    end else begin
      if (st) begin
        if (rv) pend_pc_m = tgt;
      end else begin
        pc_m   = rv ? tgt : pend_pc_m;
        pend_m = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    check_state();
  endtask

  task automatic do_reset(input logic st);
    stall          = st;
    redirect_valid = 1'b0;
    rst_n          = 1'b0;
    #2;
    chk("rst_pc", pc, 32'h0);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_count", {29'd0, fifo_count}, 32'd0);
    pc_m   = 32'h0;
    cnt_m  = 0;
    pend_m = 1'b0;
    q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n          = 1'b0;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    out_ready      = 1'b0;
    pc_m      = 32'h0;
    pend_pc_m = 32'h0;
    pend_m    = 1'b0;
    cnt_m     = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_state();

    // Free-running fetch with decode always ready.
    repeat (8) step(1'b0, 1'b0, 32'h0, 1'b1);

    // Stall held at pc 0x10 for five cycles.
    do_reset(1'b0);
    repeat (4) step(1'b0, 1'b0, 32'h0, 1'b1);
    chk("pc_at_0x10", pc, 32'h10);
    repeat (5) step(1'b1, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1);

    // Back-pressure fills the FIFO, then simultaneous push/pop while full.
    do_reset(1'b0);
    repeat (8) step(1'b0, 1'b0, 32'h0, 1'b0);
    chk("full_pc_held", pc, 32'h10);
    repeat (4) step(1'b0, 1'b0, 32'h0, 1'b1);

    // Redirect in RUN with three entries buffered.
    do_reset(1'b0);
    repeat (3) step(1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b1, 32'h203, 1'b1);
    chk("redir_pc", pc, 32'h200);
    repeat (4) step(1'b0, 1'b0, 32'h0, 1'b1);

    // Two redirects during a refill; the later one wins.
    step(1'b0, 1'b1, 32'h40, 1'b1);
    step(1'b1, 1'b1, 32'h400, 1'b1);
    step(1'b1, 1'b0, 32'h0, 1'b1);
    step(1'b1, 1'b1, 32'h800, 1'b1);
    step(1'b1, 1'b0, 32'h0, 1'b1);
    chk("pend_pc_held", pc, 32'h40);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk("pend_exit_pc", pc, 32'h800);
    repeat (3) step(1'b0, 1'b0, 32'h0, 1'b1);

    // PC wrap at the top of the address space.
    step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk("wrap_pc", pc, 32'h0);
    repeat (2) step(1'b0, 1'b0, 32'h0, 1'b0);

    // Asynchronous reset in the middle of a refill.
    step(1'b1, 1'b0, 32'h0, 1'b0);
    do_reset(1'b1);
    step(1'b1, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      logic st;
      logic rv;
      logic rdy;
      st  = ($urandom_range(0, 3) == 0);
      rv  = ($urandom_range(0, 11) == 0);
      rdy = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 399) == 0) do_reset(st);
      else step(st, rv, $urandom, rdy);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
